// File: rtl/datamem_responder.sv
// Data-memory responder: posted write buffer with load forwarding in front of
// a single-port SRAM reached through a req/ack handshake.
module datamem_responder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              MW_CPU_ON,
  input  logic [15:0]       WADDR_CPU,
  input  logic [15:0]       DATA_OUT_CPU,
  input  logic              MR_CPU_ON,
  input  logic [15:0]       RADDR_CPU,
  output logic [15:0]       DATA_IN_CPU,
  output logic              RDATA_VALID,
  output logic              MEM_BUSY,
  output logic              SRAM_REQ,
  output logic              SRAM_WE,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [15:0]       SRAM_WDATA,
  input  logic              SRAM_ACK,
  input  logic [15:0]       SRAM_RDATA
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;

  logic [ADDR_W-1:0] buf_addr [DEPTH];
  logic [15:0]       buf_data [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [1:0]        state;
  logic              rd_pending;
  logic [ADDR_W-1:0] rd_addr;

  logic              full;
  logic              enq;
  logic              deq;
  logic              ld_req;
  logic              hit;
  logic [15:0]       hit_data;
  logic [PTR_W-1:0]  idx;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic              unused_addr_bits;

  assign waddr            = WADDR_CPU[ADDR_W-1:0];
  assign raddr            = RADDR_CPU[ADDR_W-1:0];
  assign unused_addr_bits = ^{WADDR_CPU[15:ADDR_W], RADDR_CPU[15:ADDR_W]};

  assign full     = (count == CNT_W'(DEPTH));
  assign enq      = MW_CPU_ON & ~full;
  assign deq      = (state == S_WR) & SRAM_ACK;
  assign ld_req   = MR_CPU_ON & ~rd_pending;
  assign MEM_BUSY = (MW_CPU_ON & full) | rd_pending;

  // Scan oldest to youngest so the last match wins; the same-cycle store is youngest of all.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (buf_addr[idx] == raddr)) begin
        hit      = 1'b1;
        hit_data = buf_data[idx];
      end
    end
    if (enq && (waddr == raddr)) begin
      hit      = 1'b1;
      hit_data = DATA_OUT_CPU;
    end
  end

  // Buffer storage is not reset: entries are only meaningful while count covers them.
  always_ff @(posedge CLK) begin
    if (enq) begin
      buf_addr[tail] <= waddr;
      buf_data[tail] <= DATA_OUT_CPU;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      if (enq && !deq)      count <= count + 1'b1;
      else if (!enq && deq) count <= count - 1'b1;
    end
  end

  // A miss may bypass older buffered stores because none of them match its address.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      rd_pending  <= 1'b0;
      rd_addr     <= '0;
      SRAM_REQ    <= 1'b0;
      SRAM_WE     <= 1'b0;
      SRAM_ADDR   <= '0;
      SRAM_WDATA  <= '0;
      DATA_IN_CPU <= '0;
      RDATA_VALID <= 1'b0;
    end else begin
      RDATA_VALID <= 1'b0;
      if (ld_req) begin
        if (hit) begin
          DATA_IN_CPU <= hit_data;
          RDATA_VALID <= 1'b1;
        end else begin
          rd_addr    <= raddr;
          rd_pending <= 1'b1;
        end
      end
      case (state)
        S_IDLE: begin
          if (rd_pending) begin
            state     <= S_RD;
            SRAM_REQ  <= 1'b1;
            SRAM_WE   <= 1'b0;
            SRAM_ADDR <= rd_addr;
          end else if (count != '0) begin
            state      <= S_WR;
            SRAM_REQ   <= 1'b1;
            SRAM_WE    <= 1'b1;
            SRAM_ADDR  <= buf_addr[head];
            SRAM_WDATA <= buf_data[head];
          end
        end
        S_WR: begin
          if (SRAM_ACK) begin
            state    <= S_IDLE;
            SRAM_REQ <= 1'b0;
          end
        end
        S_RD: begin
          if (SRAM_ACK) begin
            state       <= S_IDLE;
            SRAM_REQ    <= 1'b0;
            DATA_IN_CPU <= SRAM_RDATA;
            RDATA_VALID <= 1'b1;
            rd_pending  <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          SRAM_REQ <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datamem_responder.sv
// Scoreboard bench for datamem_responder: SRAM model plus queues of expected
// SRAM transactions and load data, checked by an independent monitor.
module tb_datamem_responder;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] data;
  } sram_txn_t;

  logic        CLK;
  logic        RST_N;
  logic        MW_CPU_ON;
  logic [15:0] WADDR_CPU;
  logic [15:0] DATA_OUT_CPU;
  logic        MR_CPU_ON;
  logic [15:0] RADDR_CPU;
  logic [15:0] DATA_IN_CPU;
  logic        RDATA_VALID;
  logic        MEM_BUSY;
  logic        SRAM_REQ;
  logic        SRAM_WE;
  logic [7:0]  SRAM_ADDR;
  logic [15:0] SRAM_WDATA;
  logic        SRAM_ACK;
  logic [15:0] SRAM_RDATA;

  logic [15:0] mem [0:255];
  int          wcnt;
  int          ack_delay;
  bit          ack_hold;

  int          checks;
  int          errors;
  sram_txn_t   exp_sram [$];
  logic [15:0] exp_rd [$];
  sram_txn_t   mon_got;
  sram_txn_t   mon_exp;
  logic [15:0] mon_rd;

  datamem_responder #(.ADDR_W(8), .DEPTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .MW_CPU_ON(MW_CPU_ON), .WADDR_CPU(WADDR_CPU), .DATA_OUT_CPU(DATA_OUT_CPU),
    .MR_CPU_ON(MR_CPU_ON), .RADDR_CPU(RADDR_CPU),
    .DATA_IN_CPU(DATA_IN_CPU), .RDATA_VALID(RDATA_VALID), .MEM_BUSY(MEM_BUSY),
    .SRAM_REQ(SRAM_REQ), .SRAM_WE(SRAM_WE), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_WDATA(SRAM_WDATA), .SRAM_ACK(SRAM_ACK), .SRAM_RDATA(SRAM_RDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SRAM model: acks after ack_delay waiting cycles unless held off.
  assign SRAM_RDATA = mem[SRAM_ADDR];
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SRAM_ACK <= 1'b0;
      wcnt     <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0;
      mem[8'h40] <= 16'hA5A5;
    end else if (SRAM_REQ && SRAM_ACK) begin
      if (SRAM_WE) mem[SRAM_ADDR] <= SRAM_WDATA;
      SRAM_ACK <= 1'b0;
      wcnt     <= 0;
    end else if (SRAM_REQ && !ack_hold) begin
      if (wcnt >= ack_delay) SRAM_ACK <= 1'b1;
      else                   wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic mw, input logic [15:0] wa, input logic [15:0] wd,
                               input logic mr, input logic [15:0] ra);
    MW_CPU_ON    = mw;
    WADDR_CPU    = wa;
    DATA_OUT_CPU = wd;
    MR_CPU_ON    = mr;
    RADDR_CPU    = ra;
    @(posedge CLK);
    #1;
    MW_CPU_ON = 1'b0;
    MR_CPU_ON = 1'b0;
  endtask

  // Holds the store request while MEM_BUSY is sampled high before the edge.
  task automatic doStore(input logic [15:0] a, input logic [15:0] d, output int busy);
    logic b;
    MW_CPU_ON    = 1'b1;
    WADDR_CPU    = a;
    DATA_OUT_CPU = d;
    busy = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      b = MEM_BUSY;
      @(posedge CLK);
      #1;
      if (!b) break;
      busy++;
    end
    MW_CPU_ON = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    logic done;
    done = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge CLK);
      #1;
      if (exp_sram.size() == 0 && exp_rd.size() == 0 && !SRAM_REQ) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput(name, {31'h0, done}, 32'h1);
  endtask

  function automatic sram_txn_t wr(input logic [7:0] a, input logic [15:0] d);
    return '{we: 1'b1, addr: a, data: d};
  endfunction

  // Monitor: every SRAM handshake and every load response is popped and compared.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (SRAM_REQ && SRAM_ACK) begin
        mon_got = '{we: SRAM_WE, addr: SRAM_ADDR, data: (SRAM_WE ? SRAM_WDATA : 16'h0)};
        if (exp_sram.size() == 0) begin
          checkOutput("sram_unexpected", {7'h0, mon_got}, 32'h0);
          errors += (mon_got == '0) ? 1 : 0;
        end else begin
          mon_exp = exp_sram.pop_front();
          checkOutput("sram_txn", {7'h0, mon_got}, {7'h0, mon_exp});
        end
      end
      if (RDATA_VALID) begin
        if (exp_rd.size() == 0) begin
          checkOutput("rdata_unexpected", 32'h1, 32'h0);
        end else begin
          mon_rd = exp_rd.pop_front();
          checkOutput("rdata", {16'h0, DATA_IN_CPU}, {16'h0, mon_rd});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy;
    int busy_sum;
    logic seen;
    logic bad;

    checks = 0;
    errors = 0;
    ack_delay = 0;
    ack_hold  = 1'b0;
    RST_N = 1'b0;
    MW_CPU_ON = 1'b0;
    MR_CPU_ON = 1'b0;
    WADDR_CPU = '0;
    RADDR_CPU = '0;
    DATA_OUT_CPU = '0;
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(negedge CLK);
    checkOutput("rst_data", {16'h0, DATA_IN_CPU}, 32'h0);
    checkOutput("rst_valid", {31'h0, RDATA_VALID}, 32'h0);
    checkOutput("rst_busy", {31'h0, MEM_BUSY}, 32'h0);
    checkOutput("rst_req", {31'h0, SRAM_REQ}, 32'h0);
    checkOutput("rst_addr_wdata", {SRAM_WE, 7'h0, SRAM_ADDR, SRAM_WDATA}, 32'h0);
    @(posedge CLK);
    #1;

    $display("[TB] reset during a held write");
    ack_hold = 1'b1;
    applyStimulus(1'b1, 16'h0030, 16'h1234, 1'b0, 16'h0);
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (SRAM_REQ) begin
        seen = 1'b1;
        break;
      end
      @(posedge CLK);
      #1;
    end
    checkOutput("midrst_wr_req", {31'h0, seen & SRAM_WE}, 32'h1);
    #2;
    RST_N = 1'b0;
    #1;
    checkOutput("midrst_req", {31'h0, SRAM_REQ}, 32'h0);
    checkOutput("midrst_busy", {31'h0, MEM_BUSY}, 32'h0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    ack_hold = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      if (SRAM_REQ) bad = 1'b1;
    end
    checkOutput("midrst_no_write", {31'h0, bad}, 32'h0);
    @(posedge CLK);
    #1;

    $display("[TB] store forwarding");
    ack_hold = 1'b1;
    exp_sram.push_back(wr(8'h12, 16'hBEEF));
    applyStimulus(1'b1, 16'h0012, 16'hBEEF, 1'b0, 16'h0);
    exp_rd.push_back(16'hBEEF);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 16'h0012);
    checkOutput("fwd_timing", {15'h0, RDATA_VALID, DATA_IN_CPU}, {15'h0, 1'b1, 16'hBEEF});
    ack_hold = 1'b0;
    waitIdle("fwd_drain");

    $display("[TB] youngest match and same-cycle store");
    ack_hold = 1'b1;
    exp_sram.push_back(wr(8'h05, 16'h1111));
    applyStimulus(1'b1, 16'h0005, 16'h1111, 1'b0, 16'h0);
    exp_sram.push_back(wr(8'h05, 16'h2222));
    applyStimulus(1'b1, 16'h0005, 16'h2222, 1'b0, 16'h0);
    exp_rd.push_back(16'h2222);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 16'h0005);
    exp_sram.push_back(wr(8'h07, 16'h3333));
    exp_rd.push_back(16'h3333);
    applyStimulus(1'b1, 16'h0007, 16'h3333, 1'b1, 16'h0007);
    checkOutput("same_cycle_fwd", {15'h0, RDATA_VALID, DATA_IN_CPU}, {15'h0, 1'b1, 16'h3333});
    ack_hold = 1'b0;
    waitIdle("young_drain");

    $display("[TB] load miss with read priority");
    ack_hold  = 1'b1;
    ack_delay = 2;
    exp_sram.push_back(wr(8'h41, 16'h0001));
    applyStimulus(1'b1, 16'h0041, 16'h0001, 1'b0, 16'h0);
    exp_sram.push_back('{we: 1'b0, addr: 8'h40, data: 16'h0});
    exp_sram.push_back(wr(8'h42, 16'h0002));
    applyStimulus(1'b1, 16'h0042, 16'h0002, 1'b0, 16'h0);
    exp_sram.push_back(wr(8'h43, 16'h0003));
    applyStimulus(1'b1, 16'h0043, 16'h0003, 1'b0, 16'h0);
    ack_hold = 1'b0;
    exp_rd.push_back(16'hA5A5);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 16'h0040);
    bad  = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge CLK);
      if (RDATA_VALID) begin
        seen = 1'b1;
        if (MEM_BUSY || DATA_IN_CPU != 16'hA5A5) bad = 1'b1;
        break;
      end
      if (!MEM_BUSY) bad = 1'b1;
    end
    checkOutput("miss_busy_window", {30'h0, seen, bad}, 32'h2);
    @(posedge CLK);
    #1;
    waitIdle("miss_drain");

    $display("[TB] full buffer stall");
    ack_delay = 0;
    ack_hold  = 1'b1;
    fork
      begin
        repeat (8) @(posedge CLK);
        #1;
        ack_hold = 1'b0;
      end
    join_none
    busy_sum = 0;
    for (int i = 0; i < 4; i++) begin
      exp_sram.push_back(wr(8'h50 + 8'(i), 16'h5000 + 16'(i)));
      doStore(16'h0050 + 16'(i), 16'h5000 + 16'(i), busy);
      busy_sum += busy;
    end
    checkOutput("full_first_four", busy_sum, 32'h0);
    exp_sram.push_back(wr(8'h54, 16'h5004));
    doStore(16'h0054, 16'h5004, busy);
    checkOutput("full_fifth_stalls", {31'h0, (busy > 0 && busy < 50)}, 32'h1);
    waitIdle("full_drain");

    $display("[TB] wrap-around with interleaved drains");
    ack_delay = 1;
    for (int i = 0; i < 10; i++) begin
      exp_sram.push_back(wr(8'(i), 16'h0100 + 16'(i)));
      doStore(16'(i), 16'h0100 + 16'(i), busy);
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    end
    waitIdle("wrap_drain");

    checkOutput("mem_54", {16'h0, mem[8'h54]}, 32'h5004);
    checkOutput("mem_05", {16'h0, mem[8'h05]}, 32'h0105);
    checkOutput("mem_09", {16'h0, mem[8'h09]}, 32'h0109);
    checkOutput("mem_12", {16'h0, mem[8'h12]}, 32'hBEEF);
    checkOutput("mem_43", {16'h0, mem[8'h43]}, 32'h0003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
